// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register.
// Holds the 2-bit mode encoding used by the top level and by every bit cell:
//   MODE_HOLD (00), MODE_SHR (01), MODE_SHL (10), MODE_LOAD (11).
package usr_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

endpackage : usr_pkg

// File: rtl/usr_bit_cell.sv
// One bit of the universal shift register: a 4:1 mux feeding a rising-edge
// D flip-flop with a synchronous, active-high reset to a per-bit reset value.
// Ports:
//   clk     - clock, state updates on rising edge
//   rst     - synchronous active-high reset, loads rst_val
//   en      - clock enable; 0 holds the bit
//   sel     - operation select (hold / shift right / shift left / load)
//   d       - parallel load bit
//   shr_in  - bit arriving on a right shift (upper neighbour or serial fill)
//   shl_in  - bit arriving on a left shift (lower neighbour or serial fill)
//   rst_val - value taken on reset
//   q       - registered bit
module usr_bit_cell
  import usr_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  mode_t sel,
  input  logic  d,
  input  logic  shr_in,
  input  logic  shl_in,
  input  logic  rst_val,
  output logic  q
);

  logic nxt;

  // NOTE: nxt gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    nxt = q;
    unique case (sel)
      MODE_HOLD: nxt = q;
      MODE_SHR:  nxt = shr_in;
      MODE_SHL:  nxt = shl_in;
      MODE_LOAD: nxt = d;
      default:   nxt = q;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst)     q <= rst_val;
    else if (en) q <= nxt;
  end

endmodule : usr_bit_cell

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right, shift left, parallel load,
// with a saturating count of serial shifts since the last load or reset.
// Optional rotate support is compiled in when USR_ROTATE_EN is defined;
// otherwise the rot port is present but ignored.
// Parameters:
//   WIDTH     - register width (2..64)
//   RESET_VAL - value loaded into q on reset
// Ports:
//   clk      - clock
//   rst      - synchronous active-high reset (overrides en, mode, rot)
//   en       - clock enable; 0 holds q and cnt
//   mode     - 00 hold, 01 shift right, 10 shift left, 11 parallel load
//   d        - parallel load data
//   sin_msb  - serial in at bit WIDTH-1 on shift right
//   sin_lsb  - serial in at bit 0 on shift left
//   rot      - rotate select in shift modes (USR_ROTATE_EN builds only)
//   q, qbar  - register contents and its complement
//   sout_lsb - q[0];  sout_msb - q[WIDTH-1]
//   cnt      - saturating count of non-rotating shifts
//   full     - cnt == WIDTH
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int unsigned           WIDTH     = 8,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic [WIDTH-1:0]           d,
  input  logic                       sin_msb,
  input  logic                       sin_lsb,
  input  logic                       rot,
  output logic [WIDTH-1:0]           q,
  output logic [WIDTH-1:0]           qbar,
  output logic                       sout_lsb,
  output logic                       sout_msb,
  output logic [$clog2(WIDTH+1)-1:0] cnt,
  output logic                       full
);

  localparam int unsigned          CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]        CNT_MAX = CW'(WIDTH);

  mode_t sel;
  logic  msb_fill;
  logic  lsb_fill;
  logic  rotating;

  assign sel = mode_t'(mode);

`ifdef USR_ROTATE_EN
  // Rotation wraps the opposite end bit in place of the serial input.
  assign rotating = rot & ((sel == MODE_SHR) | (sel == MODE_SHL));
  assign msb_fill = rot ? q[0]       : sin_msb;
  assign lsb_fill = rot ? q[WIDTH-1] : sin_lsb;
`else
  logic unused_rot;
  assign unused_rot = rot;
  assign rotating   = 1'b0;
  assign msb_fill   = sin_msb;
  assign lsb_fill   = sin_lsb;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic shr_in;
    logic shl_in;

    if (i == WIDTH - 1) begin : g_top
      assign shr_in = msb_fill;
    end else begin : g_mid_r
      assign shr_in = q[i+1];
    end

    if (i == 0) begin : g_bot
      assign shl_in = lsb_fill;
    end else begin : g_mid_l
      assign shl_in = q[i-1];
    end

    usr_bit_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .sel     (sel),
      .d       (d[i]),
      .shr_in  (shr_in),
      .shl_in  (shl_in),
      .rst_val (RESET_VAL[i]),
      .q       (q[i])
    );
  end

  // Shift counter: direction is not tracked, rotates do not count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      if (sel == MODE_LOAD) begin
        cnt <= '0;
      end else if ((sel == MODE_SHR || sel == MODE_SHL) && !rotating
                   && cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign qbar     = ~q;
  assign sout_lsb = q[0];
  assign sout_msb = q[WIDTH-1];
  assign full     = (cnt == CNT_MAX);

endmodule : univ_shift_reg

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (WIDTH=8, RESET_VAL=8'hA5).
// The rotate expectations follow USR_ROTATE_EN as seen by this compile.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [7:0] d;
  logic       sin_msb;
  logic       sin_lsb;
  logic       rot;
  logic [7:0] q;
  logic [7:0] qbar;
  logic       sout_lsb;
  logic       sout_msb;
  logic [3:0] cnt;
  logic       full;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .d        (d),
    .sin_msb  (sin_msb),
    .sin_lsb  (sin_lsb),
    .rot      (rot),
    .q        (q),
    .qbar     (qbar),
    .sout_lsb (sout_lsb),
    .sout_msb (sout_msb),
    .cnt      (cnt),
    .full     (full)
  );

  // Advance one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] val);
    rst = 1'b0; en = 1'b1; mode = 2'b11; d = val; rot = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 2'b00; d = 8'h00;
    sin_msb = 1'b0; sin_lsb = 1'b0; rot = 1'b0;
    step();
    total++; if (q !== 8'hA5) $display("FAIL reset_q got=%h exp=a5", q); else passed++;
    total++; if (qbar !== 8'h5A) $display("FAIL reset_qbar got=%h exp=5a", qbar); else passed++;
    total++; if (cnt !== 4'd0) $display("FAIL reset_cnt got=%0d exp=0", cnt); else passed++;
    total++; if (full !== 1'b0) $display("FAIL reset_full got=%b exp=0", full); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_load_hold();
    load(8'h3C);
    total++; if (q !== 8'h3C) $display("FAIL load_q got=%h exp=3c", q); else passed++;
    en = 1'b0; mode = 2'b01; sin_msb = 1'b1;
    for (int i = 0; i < 3; i++) step();
    total++; if (q !== 8'h3C) $display("FAIL hold_en0_q got=%h exp=3c", q); else passed++;
    total++; if (cnt !== 4'd0) $display("FAIL hold_en0_cnt got=%0d exp=0", cnt); else passed++;
    en = 1'b0; mode = 2'b11; d = 8'h00;
    step();
    total++; if (q !== 8'h3C) $display("FAIL hold_en0_load_q got=%h exp=3c", q); else passed++;
    en = 1'b1; mode = 2'b00;
    step();
    total++; if (q !== 8'h3C) $display("FAIL hold_mode0_q got=%h exp=3c", q); else passed++;
  endtask

  task automatic test_shift_right();
    logic [7:0] exp_q [8] = '{8'h9E, 8'hCF, 8'hE7, 8'hF3, 8'hF9, 8'hFC, 8'hFE, 8'hFF};
    en = 1'b1; mode = 2'b01; sin_msb = 1'b1; rot = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if (q !== exp_q[i]) $display("FAIL shr_q[%0d] got=%h exp=%h", i + 1, q, exp_q[i]);
      else passed++;
      total++;
      if (cnt !== 4'(i + 1)) $display("FAIL shr_cnt[%0d] got=%0d exp=%0d", i + 1, cnt, i + 1);
      else passed++;
      total++;
      if (full !== (i == 7)) $display("FAIL shr_full[%0d] got=%b exp=%b", i + 1, full, i == 7);
      else passed++;
    end
    step();
    total++; if (cnt !== 4'd8) $display("FAIL shr_sat_cnt got=%0d exp=8", cnt); else passed++;
    total++; if (full !== 1'b1) $display("FAIL shr_sat_full got=%b exp=1", full); else passed++;
    total++; if (sout_lsb !== 1'b1) $display("FAIL shr_sout_lsb got=%b exp=1", sout_lsb); else passed++;
  endtask

  task automatic test_shift_left();
    load(8'h81);
    total++; if (sout_msb !== 1'b1) $display("FAIL shl_pre_sout_msb got=%b exp=1", sout_msb); else passed++;
    mode = 2'b10; sin_lsb = 1'b0;
    step();
    total++; if (q !== 8'h02) $display("FAIL shl_q got=%h exp=02", q); else passed++;
    total++; if (sout_msb !== 1'b0) $display("FAIL shl_sout_msb got=%b exp=0", sout_msb); else passed++;
    total++; if (cnt !== 4'd1) $display("FAIL shl_cnt got=%0d exp=1", cnt); else passed++;
    // Mixed direction still counts.
    mode = 2'b01; sin_msb = 1'b0;
    step();
    total++; if (q !== 8'h01) $display("FAIL mixed_q got=%h exp=01", q); else passed++;
    total++; if (cnt !== 4'd2) $display("FAIL mixed_cnt got=%0d exp=2", cnt); else passed++;
  endtask

  task automatic test_reset_mid();
    load(8'h00);
    mode = 2'b01; sin_msb = 1'b1;
    for (int i = 0; i < 5; i++) step();
    total++; if (cnt !== 4'd5) $display("FAIL mid_cnt got=%0d exp=5", cnt); else passed++;
    total++; if (q !== 8'hF8) $display("FAIL mid_q got=%h exp=f8", q); else passed++;
    rst = 1'b1; mode = 2'b11; d = 8'hFF;
    step();
    total++; if (q !== 8'hA5) $display("FAIL mid_rst_q got=%h exp=a5", q); else passed++;
    total++; if (cnt !== 4'd0) $display("FAIL mid_rst_cnt got=%0d exp=0", cnt); else passed++;
    total++; if (full !== 1'b0) $display("FAIL mid_rst_full got=%b exp=0", full); else passed++;
    total++; if (qbar !== 8'h5A) $display("FAIL mid_rst_qbar got=%h exp=5a", qbar); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_rotate();
    logic [7:0] exp_r;
    logic [3:0] exp_rc;
    logic [7:0] exp_l;
    logic [3:0] exp_lc;
`ifdef USR_ROTATE_EN
    exp_r = 8'hC0; exp_rc = 4'd0;
    exp_l = 8'h03; exp_lc = 4'd0;
`else
    exp_r = 8'h40; exp_rc = 4'd1;
    exp_l = 8'h02; exp_lc = 4'd1;
`endif
    load(8'h81);
    rot = 1'b1; mode = 2'b01; sin_msb = 1'b0;
    step();
    total++; if (q !== exp_r) $display("FAIL rot_r_q got=%h exp=%h", q, exp_r); else passed++;
    total++; if (cnt !== exp_rc) $display("FAIL rot_r_cnt got=%0d exp=%0d", cnt, exp_rc); else passed++;
    load(8'h81);
    rot = 1'b1; mode = 2'b10; sin_lsb = 1'b0;
    step();
    total++; if (q !== exp_l) $display("FAIL rot_l_q got=%h exp=%h", q, exp_l); else passed++;
    total++; if (cnt !== exp_lc) $display("FAIL rot_l_cnt got=%0d exp=%0d", cnt, exp_lc); else passed++;
    rot = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_hold();
    test_shift_right();
    test_shift_left();
    test_reset_mid();
    test_rotate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_univ_shift_reg
